// File: rtl/async_fifo_pkg.sv
// Shared constants and Gray-code helpers for the async_fifo_param slice.
// Helpers operate on a fixed 32-bit word. Callers size-cast in and out.
package async_fifo_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_AE_THRESH   = 4;
    localparam int GRAY_W          = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix-XOR by doubling shifts: g ^ g>>1 ^ g>>2 ^ ...
    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b = g;
        for (int unsigned s = 1; s < GRAY_W; s = s << 1) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync_n.sv
// Multi-flop vector synchronizer.
// Used only for Gray-coded pointers, so at most one bit changes per transfer.
module fifo_sync_n #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    localparam int unsigned N = STAGES;

    logic [WIDTH-1:0] r_stage [N];

    // Shift the source vector through N destination-clock flops.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < N; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_data;
            for (int unsigned i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_data = r_stage[N-1];

endmodule

// File: rtl/async_fifo_param.sv
// Dual-clock FIFO with Gray-pointer crossing and registered status flags.
// Write side runs on clk1 and read side runs on clk2.
// Optional macro ASYNC_FIFO_PARAM_ERR_EN adds sticky overflow/underflow outputs.
module async_fifo_param
    import async_fifo_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int AF_THRESH   = (2**ADDR_W) - 4,
    parameter int AE_THRESH   = DEF_AE_THRESH
) (
    input  logic              clk1,
    input  logic              clk2,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   wr_level,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              almost_empty,
    output logic [ADDR_W:0]   rd_level
`ifdef ASYNC_FIFO_PARAM_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam int DEPTH = 2**ADDR_W;
    typedef logic [ADDR_W:0] ptr_t;

    // In Gray code, a pointer that is exactly DEPTH ahead differs in its top two bits.
    localparam ptr_t FULL_MASK = ptr_t'((2**ADDR_W) + (2**(ADDR_W-1)));
    localparam ptr_t AF_T      = ptr_t'(AF_THRESH);
    localparam ptr_t AE_T      = ptr_t'(AE_THRESH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    ptr_t r_wr_ptr, r_wr_gray, w_rq_gray, w_rq_bin, w_wr_ptr_nxt, w_wr_gray_nxt, w_wr_lvl;
    ptr_t r_rd_ptr, r_rd_gray, w_wq_gray, w_wq_bin, w_rd_ptr_nxt, w_rd_gray_nxt, w_rd_lvl;
    logic w_wr_acc, w_rd_acc;

    fifo_sync_n #(.WIDTH(ADDR_W+1), .STAGES(SYNC_STAGES)) u_sync_rd2wr (
        .i_clk  (clk1),
        .i_rst  (rst),
        .i_data (r_rd_gray),
        .o_data (w_rq_gray)
    );

    fifo_sync_n #(.WIDTH(ADDR_W+1), .STAGES(SYNC_STAGES)) u_sync_wr2rd (
        .i_clk  (clk2),
        .i_rst  (rst),
        .i_data (r_wr_gray),
        .o_data (w_wq_gray)
    );

    // Write-side next-state: acceptance, next pointer and pessimistic level.
    always_comb begin
        w_wr_acc      = wr_en && !full;
        w_wr_ptr_nxt  = r_wr_ptr + ptr_t'(w_wr_acc);
        w_wr_gray_nxt = ptr_t'(bin2gray(GRAY_W'(w_wr_ptr_nxt)));
        w_rq_bin      = ptr_t'(gray2bin(GRAY_W'(w_rq_gray)));
        w_wr_lvl      = w_wr_ptr_nxt - w_rq_bin;
    end

    // Write-domain pointer and flag registers.
    // Flags use the next pointer, so full asserts on the accepting edge.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_wr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_wr_gray   <= w_wr_gray_nxt;
            full        <= (w_wr_gray_nxt == (w_rq_gray ^ FULL_MASK));
            wr_level    <= w_wr_lvl;
            almost_full <= (w_wr_lvl >= AF_T);
        end
    end

    // Storage array. It is not reset, so stale contents are unreachable after rst.
    always_ff @(posedge clk1) begin
        if (w_wr_acc) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    // Read-side next-state: acceptance, next pointer and pessimistic level.
    always_comb begin
        w_rd_acc      = rd_en && !empty;
        w_rd_ptr_nxt  = r_rd_ptr + ptr_t'(w_rd_acc);
        w_rd_gray_nxt = ptr_t'(bin2gray(GRAY_W'(w_rd_ptr_nxt)));
        w_wq_bin      = ptr_t'(gray2bin(GRAY_W'(w_wq_gray)));
        w_rd_lvl      = w_wq_bin - w_rd_ptr_nxt;
    end

    // Read-domain pointer, flag and output-data registers.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_rd_ptr     <= '0;
            r_rd_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_level     <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_rd_gray    <= w_rd_gray_nxt;
            empty        <= (w_rd_gray_nxt == w_wq_gray);
            rd_level     <= w_rd_lvl;
            almost_empty <= (w_rd_lvl <= AE_T);
            rd_valid     <= w_rd_acc;
            if (w_rd_acc) rd_data <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

`ifdef ASYNC_FIFO_PARAM_ERR_EN
    // Sticky overflow: a write was attempted while full.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst)                 overflow <= 1'b0;
        else if (wr_en && full)  overflow <= 1'b1;
    end

    // Sticky underflow: a read was attempted while empty.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst)                 underflow <= 1'b0;
        else if (rd_en && empty) underflow <= 1'b1;
    end
`endif

endmodule

// File: doc/async_fifo_param.md
ASYNC_FIFO_PARAM -- requirements
Module: async_fifo_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits (>=1).
REQ-002 SHALL have parameter ADDR_W, default 6, log2 of depth; DEPTH = 2**ADDR_W.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, cross-domain synchronizer depth (>=2).
REQ-004 SHALL have parameter AF_THRESH, default DEPTH-4, almost_full threshold in entries.
REQ-005 SHALL have parameter AE_THRESH, default 4, almost_empty threshold in entries.
REQ-006 Ports: clk1  in  1  write clock; clk2  in  1  read clock (asynchronous to clk1).
REQ-007 Ports: rst  in  1  reset rst, asynchronous, active-high, common to both domains.
REQ-008 Ports: wr_en  in  1; wr_data  in  DATA_W; full  out  1; almost_full  out  1; wr_level  out  ADDR_W+1 (clk1 domain).
REQ-009 Ports: rd_en  in  1; rd_data  out  DATA_W; rd_valid  out  1; empty  out  1; almost_empty  out  1; rd_level  out  ADDR_W+1 (clk2 domain).
REQ-010 Ports (ASYNC_FIFO_PARAM_ERR_EN only): overflow  out  1  clk1 domain; underflow  out  1  clk2 domain.

Function
REQ-011 Write accepted on clk1 rising edge iff wr_en && !full; data stored at wr_ptr[ADDR_W-1:0], wr_ptr increments.
REQ-012 Read accepted on clk2 rising edge iff rd_en && !empty; rd_data loads mem[rd_ptr[ADDR_W-1:0]] same edge, rd_ptr increments; latency 1 clk2 cycle.
REQ-013 rd_valid SHALL be 1 for exactly the clk2 cycle following an accepted read, else 0; rd_data SHALL hold its value when no read accepted.
REQ-014 Pointers ADDR_W+1 bits binary, wrap modulo 2**(ADDR_W+1) with no special case; each domain keeps a registered Gray copy.
REQ-015 Only Gray pointers cross domains, each through SYNC_STAGES flops in the destination clock.
REQ-016 full registered in clk1: 1 when next wr Gray equals synced rd Gray with top two bits inverted.
REQ-017 empty registered in clk2: 1 when next rd Gray equals synced wr Gray.
REQ-018 full SHALL assert on the same clk1 edge that accepts the DEPTH-th outstanding write; empty on the edge that accepts the last outstanding read.
REQ-019 wr_level = wr_ptr - gray2bin(synced rd Gray); rd_level = gray2bin(synced wr Gray) - rd_ptr; both ADDR_W+1 bits, range 0..DEPTH, pessimistic.
REQ-020 almost_full = (wr_level >= AF_THRESH); almost_empty = (rd_level <= AE_THRESH).
REQ-021 Write while full and read while empty SHALL be ignored: no pointer, memory or data change.
REQ-022 Simultaneous accepted write and read SHALL both complete; no lost or duplicated entries.
REQ-023 A write SHALL become readable (empty deasserts) within SYNC_STAGES+2 clk2 edges; a read frees space within SYNC_STAGES+2 clk1 edges.

Reset
REQ-024 rst SHALL clear pointers, Gray copies, synchronizer flops, rd_data=0, rd_valid=0, levels=0, almost_full=0, almost_empty=1, empty=1, full=0, overflow=0, underflow=0.
REQ-025 Memory array SHALL NOT be reset; rst mid-operation discards all contents.

Configuration
REQ-026 Macro ASYNC_FIFO_PARAM_ERR_EN defined: overflow sets sticky on wr_en && full, underflow sets sticky on rd_en && empty; cleared only by rst.
REQ-027 Macro undefined: overflow/underflow ports and logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Package async_fifo_pkg SHALL hold bin2gray/gray2bin functions and default parameter constants.
REQ-029 Sub-module fifo_sync_n SHALL implement the SYNC_STAGES-deep vector synchronizer, instanced twice.

Verification
REQ-030 Reset: assert rst 3 cycles -> empty=1, full=0, almost_empty=1, levels=0, rd_data=0.
REQ-031 Fill/drain, clk1=10ns, clk2=17ns: write 0x00..0x3F -> full=1 after 64th write, 65th write (0xAA) ignored; reads return 0x00..0x3F in order, then empty=1.
REQ-032 Read on empty: rd_en=1 for 5 clk2 -> rd_valid=0, rd_data unchanged, rd_ptr unchanged; with macro underflow=1 sticky.
REQ-033 Wrap: 300 random bytes, concurrent random wr_en/rd_en both clocks -> scoreboard exact match, pointers wrap past 127 cleanly.
REQ-034 Thresholds (AF_THRESH=60, AE_THRESH=4): 60 writes -> almost_full=1 at 60, 0 at 59; rd_level<=4 -> almost_empty=1.
REQ-035 rst after 20 writes -> empty=1, full=0; then write 0x5A, read -> rd_data=0x5A, rd_valid pulse one cycle.
